// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Holds the program counter for the single-cycle RISC-V core. It works out the
// next PC from branches, jumps, stalls, traps and halt/resume, and it counts
// retired instructions. It replaces the old PC register, PC+4 adder, branch
// shifter and branch AND gate.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   stall                  hold the PC for this cycle
//   branch, funct3         conditional branch present and its type
//   rs1_val, rs2_val       branch operands; rs1_val is also the jalr base
//   imm                    sign-extended immediate
//   jal, jalr              unconditional jumps (jalr has priority over jal)
//   trap_req               redirect to TRAP_VECTOR and record epc
//   halt_req, resume       enter and leave the HALTED state
//   pc, pc_valid           current PC and a flag that it may be fetched
//   link                   pc+4, used for jal/jalr writeback
//   taken                  the flow leaves pc+4 this cycle (combinational)
//   misaligned             one-cycle pulse after a misaligned jump target
//   epc                    PC of the instruction that trapped or faulted
//   instret                retired-instruction counter, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              IMM_PRESHIFT = 0,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  input  logic             jal,
  input  logic             jalr,
  input  logic             trap_req,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc,
  output logic             pc_valid,
  output logic [XLEN-1:0]  link,
  output logic             taken,
  output logic             misaligned,
  output logic [XLEN-1:0]  epc,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0] state;

  // Branch condition. funct3 values 010 and 011 are not branch encodings, so
  // they are never taken.
  function automatic logic branch_cond(input logic [2:0]      f,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic                   res;
    sa = a;
    sb = b;
    case (f)
      3'b000:  res = (a == b);
      3'b001:  res = (a != b);
      3'b100:  res = (sa <  sb);
      3'b101:  res = (sa >= sb);
      3'b110:  res = (a <  b);
      3'b111:  res = (a >= b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [XLEN-1:0] rel_off;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            jump_req;
  logic            fault;

  // All additions wrap modulo 2^XLEN.
  assign rel_off    = (IMM_PRESHIFT != 0) ? imm : {imm[XLEN-2:0], 1'b0};
  assign rel_target = pc + rel_off;
  assign jalr_sum   = rs1_val + imm;
  // jalr has priority over jal. Either jump has priority over a branch, but a
  // branch and jal both use the pc-relative target.
  assign target     = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : rel_target;
  assign jump_req   = jalr | jal | (branch & branch_cond(funct3, rs1_val, rs2_val));

  // taken depends only on the inputs. The misaligned check acts later, as a
  // fault on the registered side.
  assign taken    = (state == S_RUN) & ~trap_req & ~halt_req & ~stall & jump_req;
  assign fault    = taken & (target[1:0] != 2'b00);
  assign link     = pc + XLEN'(4);
  assign pc_valid = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      state      <= S_BOOT;
      misaligned <= 1'b0;
      epc        <= '0;
      instret    <= '0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          if (trap_req) begin
            pc  <= TRAP_VECTOR;
            epc <= pc;
          end else if (halt_req) begin
            state <= S_HALT;
          end else if (stall) begin
            pc <= pc;
          end else if (fault) begin
            // The misaligned target is never loaded; the fault goes straight
            // to the trap handler and does not retire.
            pc         <= TRAP_VECTOR;
            epc        <= pc;
            misaligned <= 1'b1;
          end else begin
            pc      <= taken ? target : link;
            instret <= instret + CNT_W'(1);
          end
        end
        S_HALT: begin
          // A trap leaves HALTED without recording epc: no instruction in
          // flight faulted.
          if (trap_req) begin
            pc    <= TRAP_VECTOR;
            state <= S_RUN;
          end else if (resume) begin
            state <= S_RUN;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Bench for pc_sequencer with default parameters (XLEN=64, RESET_VECTOR=0,
// TRAP_VECTOR=0x100, IMM_PRESHIFT=0, CNT_W=32). It runs a table of single-
// cycle branch/jump vectors, then hand-written sequences for reset,
// misalignment, stall, halt and trap.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [2:0]  funct3;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic [63:0] imm;
  logic        jal;
  logic        jalr;
  logic        trap_req;
  logic        halt_req;
  logic        resume;
  logic [63:0] pc;
  logic        pc_valid;
  logic [63:0] link;
  logic        taken;
  logic        misaligned;
  logic [63:0] epc;
  logic [31:0] instret;

  int checks;
  int errors;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .jal(jal), .jalr(jalr),
    .trap_req(trap_req), .halt_req(halt_req), .resume(resume), .pc(pc),
    .pc_valid(pc_valid), .link(link), .taken(taken), .misaligned(misaligned),
    .epc(epc), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] start;
    logic [2:0]  f3;
    logic        br;
    logic        jl;
    logic        jr;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] im;
    logic        exp_taken;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic add_vec(input logic [63:0] start, input logic [2:0] f3,
                         input logic br, input logic jl, input logic jr,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic exp_taken,
                         input logic [63:0] exp_pc);
    vec_t v;
    v.start = start; v.f3 = f3; v.br = br; v.jl = jl; v.jr = jr;
    v.a = a; v.b = b; v.im = im; v.exp_taken = exp_taken; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; funct3 = 3'b000; rs1_val = 0; rs2_val = 0; imm = 0;
    jal = 0; jalr = 0; trap_req = 0; halt_req = 0; resume = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Uses an aligned jalr to place the PC at a known address.
  task automatic set_pc(input logic [63:0] addr);
    clear_inputs();
    jalr = 1; rs1_val = addr;
    step();
    clear_inputs();
  endtask

  logic [31:0] i0;
  logic [63:0] e0;

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1;

    // ---------------- reset and free run ----------------
    repeat (3) step();
    chk("rst_pc", pc, 64'h0);
    chk("rst_pc_valid", {63'b0, pc_valid}, 64'h0);
    chk("rst_instret", {32'b0, instret}, 64'h0);
    chk("rst_epc", epc, 64'h0);
    chk("rst_misaligned", {63'b0, misaligned}, 64'h0);
    reset = 0;
    chk("boot_pc_valid", {63'b0, pc_valid}, 64'h0);
    step();
    chk("run_pc_valid", {63'b0, pc_valid}, 64'h1);
    chk("run_pc0", pc, 64'h0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("free_pc%0d", i), pc, 64'(4 * i));
    end
    chk("free_instret", {32'b0, instret}, 64'd5);

    // ---------------- table-driven branch/jump vectors ----------------
    add_vec(64'h20, 3'b000, 1, 0, 0, 64'd7, 64'd7, 64'd8, 1, 64'h30);  // beq eq
    add_vec(64'h20, 3'b001, 1, 0, 0, 64'd7, 64'd7, 64'd8, 0, 64'h24);  // bne eq
    add_vec(64'h20, 3'b100, 1, 0, 0, M1, 64'd1, 64'd8, 1, 64'h30);     // blt -1<1
    add_vec(64'h20, 3'b110, 1, 0, 0, M1, 64'd1, 64'd8, 0, 64'h24);     // bltu
    add_vec(64'h20, 3'b101, 1, 0, 0, 64'd5, 64'd5, 64'd8, 1, 64'h30);  // bge eq
    add_vec(64'h20, 3'b111, 1, 0, 0, M1, 64'd1, 64'd8, 1, 64'h30);     // bgeu
    add_vec(64'h20, 3'b010, 1, 0, 0, 64'd5, 64'd5, 64'd8, 0, 64'h24);  // 010 never
    add_vec(64'h20, 3'b100, 1, 0, 0, 64'd1, M1, 64'd8, 0, 64'h24);     // blt 1<-1 no
    add_vec(64'h40, 3'b000, 0, 1, 0, 64'd0, 64'd0, 64'h10, 1, 64'h60); // jal
    add_vec(64'h40, 3'b000, 0, 0, 1, 64'h1000, 64'd0, 64'd0, 1, 64'h1000); // jalr
    add_vec(64'h40, 3'b000, 0, 1, 1, 64'h200, 64'd0, 64'd4, 1, 64'h204);   // jalr beats jal
    add_vec(64'h40, 3'b000, 1, 1, 0, 64'd3, 64'd3, 64'h20, 1, 64'h80);     // jal beats beq
    add_vec(64'h40, 3'b000, 0, 1, 0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFE0, 1, 64'h0); // jal back
    add_vec(64'h40, 3'b000, 0, 0, 1, 64'h1005, 64'd0, M1, 1, 64'h1004);    // jalr neg imm

    for (int k = 0; k < vecs.size(); k++) begin
      set_pc(vecs[k].start);
      chk($sformatf("vec%0d_start", k), pc, vecs[k].start);
      branch = vecs[k].br; funct3 = vecs[k].f3; jal = vecs[k].jl; jalr = vecs[k].jr;
      rs1_val = vecs[k].a; rs2_val = vecs[k].b; imm = vecs[k].im;
      @(negedge clk);
      chk($sformatf("vec%0d_taken", k), {63'b0, taken}, {63'b0, vecs[k].exp_taken});
      chk($sformatf("vec%0d_link", k), link, vecs[k].start + 64'd4);
      step();
      chk($sformatf("vec%0d_pc", k), pc, vecs[k].exp_pc);
      clear_inputs();
    end

    // ---------------- misaligned jalr target ----------------
    set_pc(64'h50);
    i0 = instret;
    jalr = 1; rs1_val = 64'h1003;
    @(negedge clk);
    chk("mis_taken", {63'b0, taken}, 64'h1);
    step();
    clear_inputs();
    chk("mis_pc", pc, 64'h100);
    chk("mis_pulse", {63'b0, misaligned}, 64'h1);
    chk("mis_epc", epc, 64'h50);
    chk("mis_instret", {32'b0, instret}, {32'b0, i0});
    step();
    chk("mis_pulse_end", {63'b0, misaligned}, 64'h0);
    chk("mis_after_pc", pc, 64'h104);

    // ---------------- stall with jal ----------------
    set_pc(64'h80);
    i0 = instret;
    stall = 1; jal = 1; imm = 64'h10;
    @(negedge clk);
    chk("stall_taken", {63'b0, taken}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_pc%0d", i), pc, 64'h80);
      chk($sformatf("stall_instret%0d", i), {32'b0, instret}, {32'b0, i0});
    end
    stall = 0;
    step();
    chk("unstall_pc", pc, 64'hA0);
    chk("unstall_instret", {32'b0, instret}, {32'b0, i0 + 32'd1});
    clear_inputs();

    // ---------------- halt / resume ----------------
    set_pc(64'h40);
    i0 = instret;
    halt_req = 1;
    step();
    clear_inputs();
    chk("halt_valid", {63'b0, pc_valid}, 64'h0);
    chk("halt_pc", pc, 64'h40);
    jal = 1; imm = 64'h10;
    @(negedge clk);
    chk("halt_taken", {63'b0, taken}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("halt_hold%0d", i), pc, 64'h40);
    end
    chk("halt_instret", {32'b0, instret}, {32'b0, i0});
    clear_inputs();
    resume = 1;
    step();
    resume = 0;
    chk("resume_valid", {63'b0, pc_valid}, 64'h1);
    chk("resume_pc", pc, 64'h40);
    step();
    chk("resume_adv", pc, 64'h44);

    // ---------------- trap beats jal ----------------
    set_pc(64'h40);
    i0 = instret;
    trap_req = 1; jal = 1; imm = 64'h10;
    @(negedge clk);
    chk("trap_taken", {63'b0, taken}, 64'h0);
    step();
    clear_inputs();
    chk("trap_pc", pc, 64'h100);
    chk("trap_epc", epc, 64'h40);
    chk("trap_instret", {32'b0, instret}, {32'b0, i0});

    // ---------------- trap while halted ----------------
    step();
    chk("pre_halt_pc", pc, 64'h104);
    e0 = epc;
    halt_req = 1;
    step();
    halt_req = 0;
    trap_req = 1;
    step();
    trap_req = 0;
    chk("htrap_pc", pc, 64'h100);
    chk("htrap_valid", {63'b0, pc_valid}, 64'h1);
    chk("htrap_epc", epc, e0);

    // ---------------- reset while halted ----------------
    halt_req = 1;
    step();
    halt_req = 0;
    chk("hreset_pre_valid", {63'b0, pc_valid}, 64'h0);
    reset = 1;
    resume = 1;
    step();
    reset = 0;
    resume = 0;
    chk("hreset_pc", pc, 64'h0);
    chk("hreset_valid", {63'b0, pc_valid}, 64'h0);
    chk("hreset_instret", {32'b0, instret}, 64'h0);
    chk("hreset_epc", epc, 64'h0);
    step();
    chk("hreset_boot_done", {63'b0, pc_valid}, 64'h1);
    chk("hreset_boot_pc", pc, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
